// File: rtl/vga_vram_arbiter_pkg.sv
// rtl/vga_vram_arbiter_pkg.sv - shared VGA timing constants and return-tag type for the VRAM arbiter
package vga_vram_arbiter_pkg;

    localparam int POSITION_WIDTH     = 10;
    localparam int VGA_H_VISIBLE_AREA = 640;
    localparam int VGA_V_VISIBLE_AREA = 480;
    localparam int VGA_H_TOTAL        = 800;
    localparam int VGA_V_TOTAL        = 525;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_SCAN = 2'd1,
        TAG_CPU  = 2'd2
    } ret_tag_e;

endpackage

// File: rtl/vga_vram_arbiter_if.sv
// rtl/vga_vram_arbiter_if.sv - CPU request port and VRAM port bundle
interface vga_vram_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  cpu_valid;
    logic                  cpu_ready;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [7:0]            cpu_wdata;
    logic [7:0]            cpu_rdata;
    logic                  cpu_rvalid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_ready, cpu_rdata, cpu_rvalid, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_ready, cpu_rdata, cpu_rvalid, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_pixel_shifter.sv
// rtl/vga_pixel_shifter.sv - holding register and MSB-first 1 bpp serializer
module vga_pixel_shifter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] word_i,
    input  logic       word_valid_i,
    input  logic       visible_i,
    input  logic       group_start_i,
    output logic       pixel_o
);
    logic [7:0] hold_q, hold_d;
    logic [7:0] shift_q, shift_d;
    logic       vis_q;

    always_comb begin
        hold_d  = hold_q;
        shift_d = shift_q;
        if (word_valid_i) begin
            hold_d = word_i;
        end
        if (visible_i) begin
            shift_d = group_start_i ? hold_q : {shift_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q  <= '0;
            shift_q <= '0;
            vis_q   <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            shift_q <= shift_d;
            vis_q   <= visible_i;
        end
    end

    // vis_q is the previous cycle's visibility, so pixel lines up with registered sync
    assign pixel_o = shift_q[7] & vis_q;

endmodule

// File: rtl/vga_vram_arbiter.sv
// rtl/vga_vram_arbiter.sv - shares one VRAM between beam-scheduled scanout fetches and a CPU port
module vga_vram_arbiter
    import vga_vram_arbiter_pkg::*;
#(
    parameter int                    H_VISIBLE_AREA = VGA_H_VISIBLE_AREA,
    parameter int                    V_VISIBLE_AREA = VGA_V_VISIBLE_AREA,
    parameter int                    H_TOTAL        = VGA_H_TOTAL,
    parameter int                    V_TOTAL        = VGA_V_TOTAL,
    parameter int                    ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      pixel_clock,
    input  logic                      reset_n,
    input  logic [POSITION_WIDTH-1:0] h_position,
    input  logic [POSITION_WIDTH-1:0] v_position,
    vga_vram_arbiter_if.slave         bus,
    output logic                      pixel
);
    localparam logic [POSITION_WIDTH-1:0] H_VIS        = POSITION_WIDTH'(H_VISIBLE_AREA);
    localparam logic [POSITION_WIDTH-1:0] H_LAST_GROUP = POSITION_WIDTH'(H_VISIBLE_AREA - 16);
    localparam logic [POSITION_WIDTH-1:0] H_PREFETCH   = POSITION_WIDTH'(H_TOTAL - 8);
    localparam logic [POSITION_WIDTH-1:0] V_VIS        = POSITION_WIDTH'(V_VISIBLE_AREA);
    localparam logic [POSITION_WIDTH-1:0] V_LAST_VIS   = POSITION_WIDTH'(V_VISIBLE_AREA - 1);
    localparam logic [POSITION_WIDTH-1:0] V_LAST       = POSITION_WIDTH'(V_TOTAL - 1);

    logic                  group_start, visible;
    logic                  slot_group, slot_prefetch, scan_slot, reload;
    logic [ADDR_WIDTH-1:0] fetch_word;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    ret_tag_e              tag1_q, tag1_d, tag2_q;

    // Slots sit one group ahead of the beam; the prefetch slot at the end of a line
    // feeds group 0 of the next visible line.
    always_comb begin
        group_start   = (h_position[2:0] == 3'd0);
        visible       = (h_position < H_VIS) && (v_position < V_VIS);
        slot_group    = group_start && (h_position <= H_LAST_GROUP) && (v_position < V_VIS);
        slot_prefetch = (h_position == H_PREFETCH) &&
                        ((v_position == V_LAST) || (v_position < V_LAST_VIS));
        scan_slot     = slot_group || slot_prefetch;
        reload        = slot_prefetch && (v_position == V_LAST);
        fetch_word    = reload ? BASE_ADDR : fetch_addr_q;
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        tag1_d       = TAG_NONE;
        if (scan_slot) begin
            mem_addr_d   = fetch_word;
            fetch_addr_d = fetch_word + ADDR_WIDTH'(1);
            tag1_d       = TAG_SCAN;
        end else if (bus.cpu_valid) begin
            mem_addr_d  = bus.cpu_addr;
            mem_we_d    = bus.cpu_we;
            mem_wdata_d = bus.cpu_wdata;
            tag1_d      = bus.cpu_we ? TAG_NONE : TAG_CPU;
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_addr_q <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            tag1_q       <= TAG_NONE;
            tag2_q       <= TAG_NONE;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag1_q;
        end
    end

    // tag2_q lines up with the cycle in which mem_rdata answers the tagged address
    assign bus.cpu_ready  = !scan_slot;
    assign bus.cpu_rvalid = (tag2_q == TAG_CPU);
    assign bus.cpu_rdata  = (tag2_q == TAG_CPU) ? bus.mem_rdata : 8'h00;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;

    vga_pixel_shifter u_shifter (
        .clk_i         (pixel_clock),
        .rst_ni        (reset_n),
        .word_i        (bus.mem_rdata),
        .word_valid_i  (tag2_q == TAG_SCAN),
        .visible_i     (visible),
        .group_start_i (group_start),
        .pixel_o       (pixel)
    );

endmodule
